flash_loader: RTL and testbench

FLASH_LOADER -- requirements
Module: flash_loader

---
 rtl/flash_loader_pkg.sv | 18 +
 rtl/byte_shifter.sv | 25 ++
 rtl/flash_loader.sv | 143 ++++++++++++++
 tb/tb_flash_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - framing constants, loader state type and helpers for flash_loader
// CSUM state exists only when FLASH_LOADER_CHECKSUM_EN is defined.
package common;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DONE_BYTE = 8'h5A;

`ifdef FLASH_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RUN, CSUM} loader_state_e;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RUN} loader_state_e;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_shifter.sv
// rtl/byte_shifter.sv - assembles LSB-first bytes into a word
// word shows the in-flight byte already merged so the final byte is usable on its accept edge.
module byte_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [7:0]       in_byte,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] acc_q;

  assign word = shift_en ? {in_byte, acc_q[WIDTH-1:8]} : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (shift_en) begin
      acc_q <= word;
    end
  end

endmodule

// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - byte-stream record loader that writes words to flash and releases core reset
// Optional per-record checksum byte: define FLASH_LOADER_CHECKSUM_EN.
module flash_loader
  import common::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             core_rst,
  output logic [7:0]       err_count
);

  loader_state_e    state;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] addr_word;
  logic [WIDTH-1:0] data_word;
  logic             accept;

  assign accept = in_valid && in_ready;

  byte_shifter #(.WIDTH(WIDTH)) u_addr_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept && (state == ADDR)),
    .in_byte  (in_data),
    .word     (addr_word)
  );

  byte_shifter #(.WIDTH(WIDTH)) u_data_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept && (state == DATA)),
    .in_byte  (in_data),
    .word     (data_word)
  );

`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      in_ready   <= 1'b0;
      flash_en   <= 1'b0;
      core_rst   <= 1'b1;
      flash_addr <= '0;
      flash_data <= '0;
      err_count  <= 8'd0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      flash_en <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state <= ADDR;
            cnt   <= 2'd0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum   <= 8'd0;
`endif
          end else if (accept && in_data == DONE_BYTE) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end
        end
        ADDR: begin
          if (accept) begin
            cnt <= cnt + 2'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum <= sum + in_data;
`endif
            if (cnt == 2'd3) state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            cnt <= cnt + 2'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum <= sum + in_data;
            if (cnt == 2'd3) state <= CSUM;
`else
            // Misaligned records are only rejected once fully consumed, so data bytes never re-frame.
            if (cnt == 2'd3) begin
              if (addr_word[1:0] != 2'b00) begin
                state     <= IDLE;
                err_count <= sat_inc8(err_count);
              end else begin
                state      <= WRITE;
                flash_en   <= 1'b1;
                in_ready   <= 1'b0;
                flash_addr <= addr_word;
                flash_data <= data_word;
              end
            end
`endif
          end
        end
`ifdef FLASH_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (addr_word[1:0] != 2'b00 || in_data != sum) begin
              state     <= IDLE;
              err_count <= sat_inc8(err_count);
            end else begin
              state      <= WRITE;
              flash_en   <= 1'b1;
              in_ready   <= 1'b0;
              flash_addr <= addr_word;
              flash_data <= data_word;
            end
          end
        end
`endif
        WRITE: begin
          state <= IDLE;
        end
        RUN: begin
          if (accept && in_data == SYNC_BYTE) begin
            state    <= ADDR;
            cnt      <= 2'd0;
            core_rst <= 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - self-checking bench for flash_loader
module tb_flash_loader;
  import common::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_en;
  logic        core_rst;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  flash_loader #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flash_addr (flash_addr),
    .flash_data (flash_data),
    .flash_en   (flash_en),
    .core_rst   (core_rst),
    .err_count  (err_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_err = 8'd0;
  logic        exp_core_rst = 1'b1;
  logic        rst_seen = 1'b1;
  logic        gaps = 1'b0;

  logic [31:0] prog_addr[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] prog_data[5] = '{32'h02402783, 32'h02802803, 32'h07b00593, 32'h00f5f613, 32'h00466693};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rst_seen <= rst;

  // Per-cycle comparison against the bench's expectations.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_flash_en", {31'b0, flash_en}, 32'd0);
      check("rst_core_rst", {31'b0, core_rst}, 32'd1);
      check("rst_flash_addr", flash_addr, 32'd0);
      check("rst_flash_data", flash_data, 32'd0);
      check("rst_err_count", {24'b0, err_count}, 32'd0);
    end else begin
      if (flash_en) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write", {31'b0, flash_en}, 32'd0);
        end else begin
          check("write_addr", flash_addr, exp_addr_q.pop_front());
          check("write_data", flash_data, exp_data_q.pop_front());
        end
      end
      if (!rst_seen) check("in_ready", {31'b0, in_ready}, {31'b0, ~flash_en});
      check("core_rst", {31'b0, core_rst}, {31'b0, exp_core_rst});
      check("err_count_hold", {24'b0, err_count}, {24'b0, exp_err});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_err = 8'd0;
    exp_core_rst = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    in_data = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      tries++;
      if (tries > 20) begin
        check("handshake_timeout", tries, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_record(input logic [31:0] addr, input logic [31:0] data, input logic bad_csum);
    logic [7:0] sum = 8'd0;
    logic ok;
    send_byte(SYNC_BYTE);
    exp_core_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(addr[8*i +: 8]);
      sum += addr[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(data[8*i +: 8]);
      sum += data[8*i +: 8];
    end
`ifdef FLASH_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~sum : sum);
    ok = (addr[1:0] == 2'b00) && !bad_csum;
`else
    ok = (addr[1:0] == 2'b00);
`endif
    if (ok) begin
      exp_addr_q.push_back(addr);
      exp_data_q.push_back(data);
    end else if (exp_err != 8'hFF) begin
      exp_err = exp_err + 8'd1;
    end
    check("latency_flash_en", {31'b0, flash_en}, {31'b0, ok});
    check("record_err_count", {24'b0, err_count}, {24'b0, exp_err});
  endtask

  task automatic send_done();
    send_byte(DONE_BYTE);
    exp_core_rst = 1'b0;
  endtask

  task automatic send_program();
    for (int i = 0; i < 5; i++) send_record(prog_addr[i], prog_data[i], 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single record; a stray byte in IDLE is ignored without error.
    send_byte(8'h11);
    check("idle_discard_err", {24'b0, err_count}, 32'd0);
    send_record(32'h24, 32'h1, 1'b0);
    check("pin_single_addr", flash_addr, 32'h24);
    check("pin_single_data", flash_data, 32'h1);
    check("pin_single_core_rst", {31'b0, core_rst}, 32'd1);

    // Five-record program, DONE, then RUN discards and reload.
    do_reset();
    send_program();
    send_done();
    check("pin_run_core_rst", {31'b0, core_rst}, 32'd0);
    check("pin_prog_addr", flash_addr, 32'h10);
    check("pin_prog_data", flash_data, 32'h00466693);
    send_byte(8'h00);
    send_byte(DONE_BYTE);
    check("run_discard_core_rst", {31'b0, core_rst}, 32'd0);
    send_record(32'h80, 32'hDEADBEEF, 1'b0);
    check("pin_reload_core_rst", {31'b0, core_rst}, 32'd1);

    // Misaligned address is dropped, next record still lands.
    do_reset();
    send_record(32'h22, 32'h12345678, 1'b0);
    check("pin_misaligned_err", {24'b0, err_count}, 32'd1);
    check("pin_misaligned_addr_hold", flash_addr, 32'h0);
    send_record(32'h30, 32'h0BADF00D, 1'b0);
    check("pin_after_drop_data", flash_data, 32'h0BADF00D);

    // Reset mid-record abandons the partial record.
    do_reset();
    send_byte(SYNC_BYTE);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h00);
    do_reset();
    send_record(32'h8, 32'hCAFEF00D, 1'b0);
    check("pin_midrst_err", {24'b0, err_count}, 32'd0);
    check("pin_midrst_addr", flash_addr, 32'h8);

    // Same program with random stalls between bytes.
    do_reset();
    gaps = 1'b1;
    send_program();
    gaps = 1'b0;
    check("pin_gap_addr", flash_addr, 32'h10);
    check("pin_gap_data", flash_data, 32'h00466693);

`ifdef FLASH_LOADER_CHECKSUM_EN
    do_reset();
    send_record(32'h40, 32'h00001234, 1'b1);
    check("pin_csum_bad_err", {24'b0, err_count}, 32'd1);
    send_record(32'h44, 32'h00005678, 1'b0);
    check("pin_csum_good_data", flash_data, 32'h00005678);
`endif

    // Error counter saturates.
    do_reset();
    for (int i = 0; i < 257; i++) send_record(32'h1, i, 1'b0);
    check("pin_err_saturate", {24'b0, err_count}, 32'd255);

    repeat (3) @(posedge clk);
    #1;
    check("pending_writes", exp_addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
